// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared-ALU arbiter.
// Each requester's operands and opcode are packed side by side in the wide vectors.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_in1;
   logic [NUM_REQ*DATA_W-1:0] req_in2;
   logic [NUM_REQ*4-1:0]      req_op;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_result;
   logic                      rsp_zero;

   modport master (
      output req_valid, req_in1, req_in2, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero
   );

   modport slave (
      input  req_valid, req_in1, req_in2, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one single-cycle ALU between NUM_REQ requesters,
// one transaction in flight; MUL is given MUL_CYCLES settle cycles.
module alu_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_arbiter_if.slave      bus,
   output logic              busy,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [3:0]        alu_control,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero_flag
);

   localparam int         GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int         CW     = $clog2(MUL_CYCLES + 1);
   localparam logic [3:0] OP_MUL = 4'b0110;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic [GW-1:0]     grant;
   logic [GW-1:0]     last_grant;
   logic [CW-1:0]     cnt;
   logic [GW-1:0]     winner;
   logic [GW-1:0]     idx;
   logic              found;
   logic [DATA_W-1:0] win_in1;
   logic [DATA_W-1:0] win_in2;
   logic [3:0]        win_op;

   // Search starts just after the last served requester, so it goes to the back of the line.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = GW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && bus.req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      win_in1 = '0;
      win_in2 = '0;
      win_op  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == GW'(i)) begin
            win_in1 = bus.req_in1[i*DATA_W +: DATA_W];
            win_in2 = bus.req_in2[i*DATA_W +: DATA_W];
            win_op  = bus.req_op[i*4 +: 4];
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (state == IDLE && found) bus.req_ready[winner] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         alu_in1        <= '0;
         alu_in2        <= '0;
         alu_control    <= '0;
         bus.rsp_result <= '0;
         bus.rsp_zero   <= 1'b0;
         bus.rsp_valid  <= '0;
         busy           <= 1'b0;
         grant          <= '0;
         cnt            <= '0;
         last_grant     <= GW'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  alu_in1     <= win_in1;
                  alu_in2     <= win_in2;
                  alu_control <= win_op;
                  grant       <= winner;
                  cnt         <= (win_op == OP_MUL) ? CW'(MUL_CYCLES) : CW'(1);
                  busy        <= 1'b1;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bus.rsp_result       <= alu_result;
                  bus.rsp_zero         <= alu_zero_flag;
                  bus.rsp_valid[grant] <= 1'b1;
                  state                <= RESP;
               end
            end
            RESP: begin
               // Only the granted requester's ready matters; the others are ignored.
               if (bus.rsp_ready[grant]) begin
                  bus.rsp_valid <= '0;
                  last_grant    <= grant;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, vector table, scoreboard of
// expected responses, and hand-written sequences for back-pressure, reset and fairness.
module tb_alu_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_W     = 32;
   localparam int MUL_CYCLES = 2;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_BAD = 4'b1111;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        zero;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic [31:0] alu_in1, alu_in2, alu_result;
   logic [3:0]  alu_control;
   logic        alu_zero_flag;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .busy          (busy),
      .alu_in1       (alu_in1),
      .alu_in2       (alu_in2),
      .alu_control   (alu_control),
      .alu_result    (alu_result),
      .alu_zero_flag (alu_zero_flag)
   );

   // Stand-in ALU; unknown opcodes return all ones.
   always_comb begin
      case (alu_control)
         4'b0000: alu_result = alu_in1 & alu_in2;
         4'b0001: alu_result = alu_in1 | alu_in2;
         4'b0010: alu_result = alu_in1 + alu_in2;
         4'b0011: alu_result = alu_in1 ^ alu_in2;
         4'b0100: alu_result = alu_in1 - alu_in2;
         4'b0101: alu_result = alu_in1 << alu_in2[4:0];
         4'b0110: alu_result = alu_in1 * alu_in2;
         4'b0111: alu_result = alu_in1 >> alu_in2[4:0];
         4'b1000: alu_result = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
         default: alu_result = '1;
      endcase
      alu_zero_flag = (alu_result == 32'd0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int i, input logic [31:0] r, input logic z);
      exp_t e;
      e.idx  = i;
      e.res  = r;
      e.zero = z;
      sb.push_back(e);
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      bus.req_in1[i*DATA_W +: DATA_W] = a;
      bus.req_in2[i*DATA_W +: DATA_W] = b;
      bus.req_op[i*4 +: 4]            = op;
      bus.req_valid[i]                = 1'b1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      bus.req_op    = '0;
      bus.rsp_ready = '1;
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int c = 0;
      while (sb.size() != 0 && c < 50) begin
         tick();
         c++;
      end
      check(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (bus.rsp_valid == '0 && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   // Scoreboard: a response handshake completes at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (bus.rsp_valid & bus.rsp_ready) != '0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=%0h, expected no response (t=%0t)",
                     bus.rsp_valid, $time);
         end else begin
            e = sb.pop_front();
            check("rsp_valid_onehot", 64'(bus.rsp_valid), 64'd1 << e.idx);
            check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
            check("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   cyc;

      vecs[0] = '{0, 32'd3, 32'd1, OP_SUB, 32'd2,         1'b0, 2};
      vecs[1] = '{1, 32'd2, 32'd3, OP_MUL, 32'd6,         1'b0, 1 + MUL_CYCLES};
      vecs[2] = '{2, 32'd1, 32'd1, OP_SUB, 32'd0,         1'b1, 2};
      vecs[3] = '{3, 32'd1, 32'd1, OP_SLL, 32'd2,         1'b0, 2};
      vecs[4] = '{0, 32'd5, 32'd5, OP_BAD, 32'hFFFF_FFFF, 1'b0, 2};
      vecs[5] = '{3, 32'd7, 32'd3, OP_AND, 32'd3,         1'b0, 2};
      vecs[6] = '{1, 32'd0, 32'd0, OP_ADD, 32'd0,         1'b1, 2};

      // Reset state
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      bus.req_op    = '0;
      bus.rsp_ready = '1;
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_alu_in1", 64'(alu_in1), 64'd0);
      check("rst_alu_control", 64'(alu_control), 64'd0);
      check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
      do_reset();

      // Table of single transactions: latency, grant and operand stability
      for (int v = 0; v < 7; v++) begin
         set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
         #1;
         check("tbl_req_ready", 64'(bus.req_ready), 64'd1 << vecs[v].idx);
         push(vecs[v].idx, vecs[v].res, vecs[v].zero);
         tick();
         bus.req_valid = '0;
         cyc = 0;
         while (bus.rsp_valid == '0 && cyc < 20) begin
            check("tbl_alu_in1_stable", 64'(alu_in1), 64'(vecs[v].a));
            check("tbl_alu_in2_stable", 64'(alu_in2), 64'(vecs[v].b));
            check("tbl_alu_control_stable", 64'(alu_control), 64'(vecs[v].op));
            tick();
            cyc++;
         end
         check("tbl_latency", 64'(cyc + 1), 64'(vecs[v].lat));
         check("tbl_busy_resp", 64'(busy), 64'd1);
         tick();
         check("tbl_busy_idle", 64'(busy), 64'd0);
      end
      drain("tbl_drain");

      // All four requesting ADD 1+1 with responses always accepted: 0,1,2,3,0
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'd1, 32'd1, OP_ADD);
      push(0, 32'd2, 1'b0);
      push(1, 32'd2, 1'b0);
      push(2, 32'd2, 1'b0);
      push(3, 32'd2, 1'b0);
      push(0, 32'd2, 1'b0);
      cyc = 0;
      while (sb.size() != 0 && cyc < 40) begin
         tick();
         cyc++;
      end
      bus.req_valid = '0;
      check("rr_all_served", 64'(sb.size()), 64'd0);
      check("rr_throughput", 64'(cyc <= 15), 64'd1);
      tick();
      check("rr_idle_after", 64'(busy), 64'd0);

      // Response back-pressure on requester 2 stalls the arbiter
      bus.rsp_ready = 4'b1011;
      set_req(2, 32'd1, 32'd1, OP_SUB);
      push(2, 32'd0, 1'b1);
      #1;
      check("bp_grant2", 64'(bus.req_ready), 64'b0100);
      tick();
      bus.req_valid[2] = 1'b0;
      set_req(0, 32'd1, 32'd1, OP_ADD);
      push(0, 32'd2, 1'b0);
      #1;
      check("bp_no_grant_exec", 64'(bus.req_ready), 64'd0);
      tick();
      check("bp_rsp_zero", 64'(bus.rsp_zero), 64'd1);
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid_held", 64'(bus.rsp_valid), 64'b0100);
         check("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
         check("bp_busy_held", 64'(busy), 64'd1);
         tick();
      end
      bus.rsp_ready[2] = 1'b1;
      #1;
      check("bp_release_cycle_no_grant", 64'(bus.req_ready), 64'd0);
      tick();
      check("bp_grant0_after_release", 64'(bus.req_ready), 64'b0001);
      tick();
      bus.req_valid = '0;
      drain("bp_drain");

      // Reset during EXEC drops the transaction
      bus.rsp_ready = '1;
      set_req(3, 32'd1, 32'd1, OP_SLL);
      tick();
      check("rst_mid_busy_before", 64'(busy), 64'd1);
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_mid_alu_in1", 64'(alu_in1), 64'd0);
      check("rst_mid_alu_in2", 64'(alu_in2), 64'd0);
      check("rst_mid_alu_control", 64'(alu_control), 64'd0);
      check("rst_mid_rsp_result", 64'(bus.rsp_result), 64'd0);
      check("rst_mid_rsp_zero", 64'(bus.rsp_zero), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check("rst_mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
      end

      // Pointer wrap after reset and fairness on re-request
      set_req(0, 32'd2, 32'd2, OP_ADD);
      set_req(2, 32'd3, 32'd3, OP_ADD);
      #1;
      check("wrap_req0_first", 64'(bus.req_ready), 64'b0001);
      push(0, 32'd4, 1'b0);
      tick();
      wait_valid(cyc);
      check("wrap_rsp_latency", 64'(cyc), 64'd1);
      tick();
      check("fair_req2_next", 64'(bus.req_ready), 64'b0100);
      push(2, 32'd6, 1'b0);
      tick();
      bus.req_valid = '0;
      drain("fair_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
